// File: rtl/regfile_bus_arbiter.sv
// Round-robin arbiter that gives two requesters access to the register-file bus.
// Each transfer runs SETUP (select only), XFER (enable + done). A fetch may then add
// TURN cycles of idle bus turnaround. Every output is decoded from registered state only.
module regfile_bus_arbiter #(
  parameter int unsigned TURN_CYCLES = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       req0,
  input  logic       req1,
  input  logic       store0,
  input  logic       store1,
  input  logic [2:0] reg0,
  input  logic [2:0] reg1,
  output logic       gnt0,
  output logic       gnt1,
  output logic       done0,
  output logic       done1,
  output logic       read_data,
  output logic       write_data,
  output logic [2:0] input_select,
  output logic [2:0] output_select,
  output logic       busy
);

  typedef enum logic [1:0] {StIdle, StSetup, StXfer, StTurn} state_e;

  // The counter is loaded with TURN_CYCLES-1 so that TURN lasts exactly TURN_CYCLES cycles.
  localparam logic [1:0] TurnLoad = (TURN_CYCLES > 0) ? 2'(TURN_CYCLES - 1) : 2'd0;

  state_e     state_q, state_d;
  logic       winner_q, winner_d;   // 0 = requester 0, 1 = requester 1
  logic       store_q, store_d;
  logic [2:0] idx_q, idx_d;
  logic       last_q, last_d;       // requester most recently granted into XFER
  logic [1:0] cnt_q, cnt_d;
  logic       win_req;
  logic       active;
  logic       xfer;

  // State and latched-request registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      winner_q <= 1'b0;
      store_q  <= 1'b0;
      idx_q    <= 3'b000;
      last_q   <= 1'b1;
      cnt_q    <= 2'd0;
    end else begin
      state_q  <= state_d;
      winner_q <= winner_d;
      store_q  <= store_d;
      idx_q    <= idx_d;
      last_q   <= last_d;
      cnt_q    <= cnt_d;
    end
  end

  // Next-state logic, arbitration and request latching.
  always_comb begin
    state_d  = state_q;
    winner_d = winner_q;
    store_d  = store_q;
    idx_d    = idx_q;
    last_d   = last_q;
    cnt_d    = cnt_q;
    win_req  = winner_q ? req1 : req0;
    unique case (state_q)
      StIdle: begin
        if (req0 || req1) begin
          // On a tie, grant the requester that was not granted last.
          winner_d = (req0 && req1) ? ~last_q : req1;
          store_d  = winner_d ? store1 : store0;
          idx_d    = winner_d ? reg1 : reg0;
          state_d  = StSetup;
        end
      end
      StSetup: begin
        if (!win_req) begin
          state_d = StIdle;  // aborted grant leaves the round-robin pointer untouched
        end else begin
          state_d = StXfer;
          last_d  = winner_q;
        end
      end
      StXfer: begin
        if (store_q || (TURN_CYCLES == 0)) begin
          state_d = StIdle;
        end else begin
          state_d = StTurn;
          cnt_d   = TurnLoad;
        end
      end
      StTurn: begin
        if (cnt_q == 2'd0) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Moore output decode from registered state.
  always_comb begin
    active        = (state_q == StSetup) || (state_q == StXfer);
    xfer          = (state_q == StXfer);
    gnt0          = active && !winner_q;
    gnt1          = active && winner_q;
    done0         = xfer && !winner_q;
    done1         = xfer && winner_q;
    read_data     = xfer && store_q;
    write_data    = xfer && !store_q;
    input_select  = (active && store_q) ? idx_q : 3'b000;
    output_select = (active && !store_q) ? idx_q : 3'b000;
    busy          = (state_q != StIdle);
  end

endmodule

// File: tb/tb_regfile_bus_arbiter.sv
// Directed bench for regfile_bus_arbiter with TURN_CYCLES = 2.
// Outputs are packed as {gnt0,gnt1,done0,done1,read_data,write_data,busy,input_select,output_select}.
module tb_regfile_bus_arbiter;

  logic       clock;
  logic       reset;
  logic       req0, req1, store0, store1;
  logic [2:0] reg0, reg1;
  logic       gnt0, gnt1, done0, done1, read_data, write_data, busy;
  logic [2:0] input_select, output_select;
  logic [12:0] outs;

  int n_checks;
  int n_fail;

  regfile_bus_arbiter #(.TURN_CYCLES(2)) dut (
    .clock         (clock),
    .reset         (reset),
    .req0          (req0),
    .req1          (req1),
    .store0        (store0),
    .store1        (store1),
    .reg0          (reg0),
    .reg1          (reg1),
    .gnt0          (gnt0),
    .gnt1          (gnt1),
    .done0         (done0),
    .done1         (done1),
    .read_data     (read_data),
    .write_data    (write_data),
    .input_select  (input_select),
    .output_select (output_select),
    .busy          (busy)
  );

  assign outs = {gnt0, gnt1, done0, done1, read_data, write_data, busy,
                 input_select, output_select};

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance one rising edge and settle 1 ns past it.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    req0 = 0; req1 = 0; store0 = 0; store1 = 0; reg0 = 0; reg1 = 0;
    step();
    step();
    n_checks++;
    if (outs !== 13'b0) begin
      $display("FAIL reset_outputs: got %b expected %b", outs, 13'b0);
      n_fail++;
    end
    reset = 1'b1;
    step();
    n_checks++;
    if (outs !== 13'b0) begin
      $display("FAIL idle_after_release: got %b expected %b", outs, 13'b0);
      n_fail++;
    end
  endtask

  task automatic test_store();
    req0 = 1; store0 = 1; reg0 = 3'b011;
    step();
    n_checks++;
    if (outs !== 13'b10_00_00_1_011_000) begin
      $display("FAIL store_setup: got %b expected %b", outs, 13'b10_00_00_1_011_000);
      n_fail++;
    end
    step();
    n_checks++;
    if (outs !== 13'b10_10_10_1_011_000) begin
      $display("FAIL store_xfer: got %b expected %b", outs, 13'b10_10_10_1_011_000);
      n_fail++;
    end
    req0 = 0;
    step();
    n_checks++;
    if (outs !== 13'b0) begin
      $display("FAIL store_idle: got %b expected %b", outs, 13'b0);
      n_fail++;
    end
  endtask

  task automatic test_fetch_turn();
    req1 = 1; store1 = 0; reg1 = 3'b110;
    step();
    n_checks++;
    if (outs !== 13'b01_00_00_1_000_110) begin
      $display("FAIL fetch_setup: got %b expected %b", outs, 13'b01_00_00_1_000_110);
      n_fail++;
    end
    step();
    n_checks++;
    if (outs !== 13'b01_01_01_1_000_110) begin
      $display("FAIL fetch_xfer: got %b expected %b", outs, 13'b01_01_01_1_000_110);
      n_fail++;
    end
    req1 = 0;
    for (int i = 0; i < 2; i++) begin
      step();
      n_checks++;
      if (outs !== 13'b00_00_00_1_000_000) begin
        $display("FAIL fetch_turn%0d: got %b expected %b", i, outs, 13'b00_00_00_1_000_000);
        n_fail++;
      end
    end
    step();
    n_checks++;
    if (outs !== 13'b0) begin
      $display("FAIL fetch_idle: got %b expected %b", outs, 13'b0);
      n_fail++;
    end
  endtask

  // Both requesters held high; pointer is 1 after the fetch, so requester 0 wins first.
  task automatic test_contention();
    logic [12:0] exp_setup;
    logic [12:0] exp_xfer;
    req0 = 1; store0 = 1; reg0 = 3'b001;
    req1 = 1; store1 = 1; reg1 = 3'b010;
    for (int k = 0; k < 4; k++) begin
      exp_setup = (k % 2 == 0) ? 13'b10_00_00_1_001_000 : 13'b01_00_00_1_010_000;
      exp_xfer  = (k % 2 == 0) ? 13'b10_10_10_1_001_000 : 13'b01_01_10_1_010_000;
      step();
      n_checks++;
      if (outs !== exp_setup) begin
        $display("FAIL contention_setup%0d: got %b expected %b", k, outs, exp_setup);
        n_fail++;
      end
      step();
      n_checks++;
      if (outs !== exp_xfer) begin
        $display("FAIL contention_xfer%0d: got %b expected %b", k, outs, exp_xfer);
        n_fail++;
      end
      step();
      n_checks++;
      if (outs !== 13'b0) begin
        $display("FAIL contention_idle%0d: got %b expected %b", k, outs, 13'b0);
        n_fail++;
      end
    end
    req0 = 0; req1 = 0;
  endtask

  task automatic test_abort();
    req0 = 1; store0 = 1; reg0 = 3'b100;
    req1 = 1; store1 = 1; reg1 = 3'b010;
    step();
    n_checks++;
    if (outs !== 13'b10_00_00_1_100_000) begin
      $display("FAIL abort_setup: got %b expected %b", outs, 13'b10_00_00_1_100_000);
      n_fail++;
    end
    req0 = 0; req1 = 0;
    step();
    n_checks++;
    if (outs !== 13'b0) begin
      $display("FAIL abort_idle: got %b expected %b", outs, 13'b0);
      n_fail++;
    end
    req0 = 1; req1 = 1;
    step();
    n_checks++;
    if (outs !== 13'b10_00_00_1_100_000) begin
      $display("FAIL abort_retie: got %b expected %b", outs, 13'b10_00_00_1_100_000);
      n_fail++;
    end
    req1 = 0;
    step();
    n_checks++;
    if (outs !== 13'b10_10_10_1_100_000) begin
      $display("FAIL abort_retie_xfer: got %b expected %b", outs, 13'b10_10_10_1_100_000);
      n_fail++;
    end
    req0 = 0;
    step();
  endtask

  // Fetch by requester 0 sets the pointer to 0; reset must restore it to 1.
  task automatic test_reset_mid_xfer();
    req0 = 1; store0 = 0; reg0 = 3'b101;
    step();
    n_checks++;
    if (outs !== 13'b10_00_00_1_000_101) begin
      $display("FAIL rst_fetch_setup: got %b expected %b", outs, 13'b10_00_00_1_000_101);
      n_fail++;
    end
    step();
    n_checks++;
    if (outs !== 13'b10_10_01_1_000_101) begin
      $display("FAIL rst_fetch_xfer: got %b expected %b", outs, 13'b10_10_01_1_000_101);
      n_fail++;
    end
    #1 reset = 1'b0;
    #1;
    n_checks++;
    if (outs !== 13'b0) begin
      $display("FAIL rst_immediate: got %b expected %b", outs, 13'b0);
      n_fail++;
    end
    req0 = 0;
    for (int i = 0; i < 2; i++) begin
      step();
      n_checks++;
      if (outs !== 13'b0) begin
        $display("FAIL rst_held%0d: got %b expected %b", i, outs, 13'b0);
        n_fail++;
      end
    end
    reset = 1'b1;
    step();
    n_checks++;
    if (outs !== 13'b0) begin
      $display("FAIL rst_release: got %b expected %b", outs, 13'b0);
      n_fail++;
    end
    req0 = 1; store0 = 1; reg0 = 3'b111;
    req1 = 1; store1 = 1; reg1 = 3'b001;
    step();
    n_checks++;
    if (outs !== 13'b10_00_00_1_111_000) begin
      $display("FAIL rst_pointer_tie: got %b expected %b", outs, 13'b10_00_00_1_111_000);
      n_fail++;
    end
    req0 = 0; req1 = 0;
    step();
    step();
  endtask

  task automatic test_random_invariants();
    for (int i = 0; i < 300; i++) begin
      req0 = 1'($urandom_range(0, 1));
      req1 = 1'($urandom_range(0, 1));
      store0 = 1'($urandom_range(0, 1));
      store1 = 1'($urandom_range(0, 1));
      reg0 = 3'($urandom_range(0, 7));
      reg1 = 3'($urandom_range(0, 7));
      step();
      n_checks++;
      if ((gnt0 && gnt1) || (read_data && write_data) || (done0 && done1)) begin
        $display("FAIL rand_exclusive%0d: got %b expected no overlap", i, outs);
        n_fail++;
      end
      n_checks++;
      if ((read_data || write_data) !== (done0 || done1)) begin
        $display("FAIL rand_enable_xfer%0d: got %b expected enable==done", i, outs);
        n_fail++;
      end
      n_checks++;
      if ((done0 && !gnt0) || (done1 && !gnt1) || ((gnt0 || gnt1) && !busy)) begin
        $display("FAIL rand_done_gnt%0d: got %b expected done within gnt", i, outs);
        n_fail++;
      end
    end
    req0 = 0; req1 = 0;
    for (int i = 0; i < 5; i++) step();
    n_checks++;
    if (outs !== 13'b0) begin
      $display("FAIL rand_drain: got %b expected %b", outs, 13'b0);
      n_fail++;
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    test_reset();
    test_store();
    test_fetch_turn();
    test_contention();
    test_abort();
    test_reset_mid_xfer();
    test_random_invariants();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_bus_arbiter.md
REGFILE_BUS_ARBITER -- requirements
Module: regfile_bus_arbiter

Interface
REQ-001 Parameter: TURN_CYCLES, default 1, number of idle bus-turnaround cycles inserted after a fetch transfer (legal 0..3).
REQ-002 Port: clock  input  1  single rising-edge clock for all state.
REQ-003 Port: reset  input  1  asynchronous, active-low reset.
REQ-004 Port: req0 / req1  input  1 each  transfer request from requester 0 (execute stage) / requester 1 (load-store unit).
REQ-005 Port: store0 / store1  input  1 each  op select: 1 = store (bus -> register), 0 = fetch (register -> bus).
REQ-006 Port: reg0 / reg1  input  3 each  target register index, A=000 ... H=111.
REQ-007 Port: gnt0 / gnt1  output  1 each  requester owns the register-file bus.
REQ-008 Port: done0 / done1  output  1 each  one-cycle pulse; the transfer happens in this cycle.
REQ-009 Port: read_data  output  1  register file captures data_bus into input_select.
REQ-010 Port: write_data  output  1  register file drives output_select onto data_bus.
REQ-011 Port: input_select / output_select  output  3 each  register index for store / fetch.
REQ-012 Port: busy  output  1  high in every state except IDLE.

Function
REQ-013 All outputs SHALL be registered (Moore outputs decoded from registered state); no combinational path from inputs to outputs.
REQ-014 FSM states SHALL be IDLE, SETUP, XFER, TURN.
REQ-015 IDLE: if any req is high, latch the winner, its op and its register index, and go to SETUP; otherwise stay in IDLE.
REQ-016 SETUP (1 cycle): assert the winner's gnt; drive input_select or output_select with the latched index; read_data = write_data = 0.
REQ-017 SETUP: if the winner's req is low in this cycle (abort), return to IDLE with no enable and no done pulse.
REQ-018 XFER (1 cycle): keep gnt; assert read_data (store) or write_data (fetch), never both; pulse the winner's done.
REQ-019 XFER exit: a store goes to IDLE; a fetch goes to TURN when TURN_CYCLES > 0, otherwise to IDLE.
REQ-020 TURN: all enables and gnts low; a down-counter holds the state for exactly TURN_CYCLES cycles, then goes to IDLE.
REQ-021 Latency: req high at edge N gives gnt in cycle N+1, done and enable in cycle N+2, and IDLE in cycle N+3 (store, or fetch with TURN_CYCLES = 0).
REQ-022 Arbitration SHALL be round-robin. With both reqs high in IDLE, grant the requester not granted last; a sole requester always wins.
REQ-023 The last-granted pointer SHALL update only on entry to XFER; an aborted grant does not update it.
REQ-024 After reset the last-granted pointer SHALL equal 1, so requester 0 wins the first tie.
REQ-025 Requesters SHALL hold store and reg stable while req is high. The arbiter uses only the values latched in IDLE; later changes are ignored.
REQ-026 A req still high in the IDLE cycle after done SHALL count as a new request.
REQ-027 Only one gnt, at most one enable, and at most one done SHALL be high in any cycle.
REQ-028 Select lines not used by the current op SHALL be driven to 000.

Reset
REQ-029 reset low SHALL force IDLE asynchronously, clear all outputs to 0, clear the TURN counter, and set the last-granted pointer to 1.
REQ-030 Reset asserted during SETUP, XFER or TURN SHALL drop gnt, enables and done in the same cycle, with no partial pulse after release.
REQ-031 The first arbitration SHALL happen at the first rising edge after reset goes high.

Verification
REQ-032 Single store: req0=1, store0=1, reg0=011 -> gnt0 in cycle N+1, input_select=011; read_data=1 and done0=1 in cycle N+2; IDLE in cycle N+3.
REQ-033 Fetch with TURN_CYCLES=2: req1=1, store1=0, reg1=110 -> write_data=1, output_select=110, done1=1 in N+2; busy=1 with no enables in N+3..N+4; IDLE in N+5.
REQ-034 Contention: req0 and req1 held high continuously after reset -> grants alternate 0,1,0,1 and each done pulse matches its gnt.
REQ-035 Abort: req0 dropped during SETUP -> no read_data or write_data, no done0; IDLE next cycle; the next tie is still won by requester 0.
REQ-036 Reset mid-XFER: reset low during a fetch XFER -> write_data, gnt and done go to 0 immediately; all outputs stay 0 until release.
REQ-037 Invariant check over random traffic: never two gnts, never read_data and write_data together, never an enable outside XFER.
